// File: rtl/pal_pkg.sv
// Shared definitions for the PAL configuration path: chain length helpers
// and the loader state encoding. The PAL core uses the same length function,
// so loader and core agree on the image size by construction.
package pal_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } pal_state_e;

  // Total configuration bits: AND-plane (true + complement inputs) plus OR-plane.
  function automatic int pal_sr_len(input int n, input int p, input int m);
    return 2 * n * p + p * m;
  endfunction

  // Bytes needed to carry sr_len bits; the last byte may be partially used.
  function automatic int pal_nbytes(input int sr_len);
    return (sr_len + 7) / 8;
  endfunction

endpackage

// File: rtl/pal_byte_ser.sv
// Byte serialiser: holds one configuration byte and its remaining bit count,
// presenting the current MSB as the serial bit. The register is cleared on the
// final shift so the serial bit idles low between bytes.
module pal_byte_ser (
  input  logic       clk,
  input  logic       res,
  input  logic       clear,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] data,
  input  logic [3:0] load_cnt,
  output logic       msb,
  output logic       last_bit
);

  logic [7:0] byte_reg;
  logic [3:0] bit_cnt;

  // Capture a new byte, or shift out one bit per cycle MSB first.
  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (res || clear) begin
      byte_reg <= '0;
      bit_cnt  <= '0;
    end else if (load) begin
      byte_reg <= data;
      bit_cnt  <= load_cnt;
    end else if (shift) begin
      if (last_bit) begin
        byte_reg <= '0;
        bit_cnt  <= '0;
      end else begin
        byte_reg <= {byte_reg[6:0], 1'b0};
        bit_cnt  <= bit_cnt - 4'd1;
      end
    end
  end

  assign msb      = byte_reg[7];
  assign last_bit = (bit_cnt == 4'd1);

endmodule

// File: rtl/pal_cfg_loader.sv
// Configuration front-end for the PAL core. Accepts image bytes over a
// valid/ready handshake and streams them MSB first into the PAL en/cfg shift
// chain, counting exactly SR_LEN shifted bits before flagging completion.
module pal_cfg_loader
  import pal_pkg::*;
#(
  parameter int N = 8,
  parameter int P = 8,
  parameter int M = 8
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       sr_en,
  output logic       sr_cfg,
  output logic       busy,
  output logic       cfg_done
);

  localparam int SR_LEN      = pal_sr_len(N, P, M);
  localparam int NBYTES      = pal_nbytes(SR_LEN);
  // Bit offset at which the final (possibly partial) byte begins.
  localparam int LAST_OFFSET = (NBYTES - 1) * 8;
  localparam int LAST_BITS   = SR_LEN - LAST_OFFSET;
  localparam int TW          = $clog2(SR_LEN + 1);

  pal_state_e    state;
  logic [TW-1:0] total_cnt;
  logic          accept;
  logic          do_shift;
  logic          last_bit;
  logic          msb;
  logic [3:0]    load_cnt;

  // start masks in_ready so a restart never consumes the byte on offer.
  assign in_ready = (state == FETCH) && !start && !res;
  assign accept   = in_ready && in_valid;
  assign do_shift = (state == SHIFT) && !start && !res;
  // Only the final byte carries fewer than 8 meaningful bits.
  assign load_cnt = (total_cnt == TW'(LAST_OFFSET)) ? 4'(LAST_BITS) : 4'd8;

  pal_byte_ser u_byte_ser (
    .clk      (clk),
    .res      (res),
    .clear    (start),
    .load     (accept),
    .shift    (do_shift),
    .data     (in_data),
    .load_cnt (load_cnt),
    .msb      (msb),
    .last_bit (last_bit)
  );

  // The serial bit comes straight from the byte register flop.
  assign sr_cfg = msb;

  // Load sequencing FSM with registered shift enable and status outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      total_cnt <= '0;
      sr_en     <= 1'b0;
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= FETCH;
            total_cnt <= '0;
            busy      <= 1'b1;
            cfg_done  <= 1'b0;
          end
        end
        FETCH: begin
          if (start) begin
            total_cnt <= '0;
          end else if (accept) begin
            state <= SHIFT;
            sr_en <= 1'b1;
          end
        end
        SHIFT: begin
          if (start) begin
            state     <= FETCH;
            total_cnt <= '0;
            sr_en     <= 1'b0;
          end else begin
            total_cnt <= total_cnt + TW'(1);
            if (last_bit) begin
              sr_en <= 1'b0;
              if (total_cnt == TW'(SR_LEN - 1)) begin
                state    <= DONE;
                busy     <= 1'b0;
                cfg_done <= 1'b1;
              end else begin
                state <= FETCH;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench for pal_cfg_loader: a default-size instance (192 bits)
// and a small instance (N=2,P=3,M=3 -> 21 bits) share one clock. A monitor
// records every shifted bit into a queue and a model PAL chain; expected
// streams are derived directly from the byte image.
module tb_pal_cfg_loader;

  typedef logic [7:0] bytes_q_t[$];

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [20:0] exp_chain;
    int          exp_en;
  } vec_t;

  logic       clk = 1'b0;
  logic       res[2];
  logic       start[2];
  logic [7:0] in_data[2];
  logic       in_valid[2];
  logic       in_ready[2];
  logic       sr_en[2];
  logic       sr_cfg[2];
  logic       busy[2];
  logic       cfg_done[2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int           en_cnt[2]        = '{0, 0};
  int           last_en_cyc[2]   = '{0, 0};
  int           done_rise_cyc[2] = '{-1, -1};
  logic         done_prev[2]     = '{1'b0, 1'b0};
  logic [191:0] chain[2]         = '{192'd0, 192'd0};
  bit           bits0[$];
  bit           bits1[$];

  always #5 clk = ~clk;

  pal_cfg_loader u_dut (
    .clk      (clk),
    .res      (res[0]),
    .start    (start[0]),
    .in_data  (in_data[0]),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .sr_en    (sr_en[0]),
    .sr_cfg   (sr_cfg[0]),
    .busy     (busy[0]),
    .cfg_done (cfg_done[0])
  );

  pal_cfg_loader #(.N(2), .P(3), .M(3)) u_small (
    .clk      (clk),
    .res      (res[1]),
    .start    (start[1]),
    .in_data  (in_data[1]),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .sr_en    (sr_en[1]),
    .sr_cfg   (sr_cfg[1]),
    .busy     (busy[1]),
    .cfg_done (cfg_done[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: model of the PAL chain plus a log of every shifted bit.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sr_en[k]) begin
        en_cnt[k]++;
        chain[k]       = {chain[k][190:0], sr_cfg[k]};
        last_en_cyc[k] = cyc;
        if (k == 0) bits0.push_back(sr_cfg[k]);
        else        bits1.push_back(sr_cfg[k]);
      end
      if (cfg_done[k] && !done_prev[k]) done_rise_cyc[k] = cyc;
      done_prev[k] = cfg_done[k];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: image bit i is byte i/8, bit 7-(i%8); first streamed bit ends at the chain MSB.
  function automatic bit model_bit(input bytes_q_t img, input int i);
    logic [7:0] b;
    b = img[i / 8];
    return b[7 - (i % 8)];
  endfunction

  function automatic logic [191:0] model_chain(input bytes_q_t img, input int sr_len);
    logic [191:0] c;
    c = '0;
    for (int i = 0; i < sr_len; i++) c[sr_len - 1 - i] = model_bit(img, i);
    return c;
  endfunction

  function automatic logic [191:0] len_mask(input int sr_len);
    logic [191:0] m;
    m = '0;
    for (int i = 0; i < sr_len; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic do_reset(input int k);
    res[k]      = 1'b1;
    start[k]    = 1'b0;
    in_valid[k] = 1'b0;
    in_data[k]  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    res[k] = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    #1;
  endtask

  task automatic send_byte(input int k, input logic [7:0] b, input int gap, output bit gap_ok);
    int w;
    gap_ok = 1'b1;
    if (gap > 0) begin
      in_valid[k] = 1'b0;
      w = 0;
      while (!in_ready[k] && w < 40) begin
        @(negedge clk);
        w++;
      end
      repeat (gap) begin
        if (!in_ready[k]) gap_ok = 1'b0;
        @(negedge clk);
      end
    end
    in_data[k]  = b;
    in_valid[k] = 1'b1;
    w = 0;
    while (!in_ready[k] && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", in_ready[k], 1);
    @(negedge clk);
  endtask

  task automatic run_load(input int k, input bytes_q_t img, input int sr_len, input bit do_start,
                          input int gap_every, input int gap_len, output bit gaps_ok);
    int base, en0, w, mism, gap;
    bit ok;
    base    = (k == 0) ? bits0.size() : bits1.size();
    en0     = en_cnt[k];
    gaps_ok = 1'b1;
    if (do_start) begin
      pulse_start(k);
      check("start_busy_done", {busy[k], cfg_done[k]}, 2'b10);
    end
    for (int i = 0; i < img.size(); i++) begin
      gap = (gap_every > 0 && (i % gap_every) == gap_every - 1) ? gap_len : 0;
      send_byte(k, img[i], gap, ok);
      gaps_ok &= ok;
    end
    w = 0;
    while (!cfg_done[k] && w < 40) begin
      @(negedge clk);
      w++;
    end
    #1;
    check("cfg_done", cfg_done[k], 1);
    check("busy_after_done", busy[k], 0);
    check("en_count", en_cnt[k] - en0, sr_len);
    mism = 0;
    for (int i = 0; i < sr_len; i++) begin
      if (k == 0) begin
        if (base + i >= bits0.size() || bits0[base + i] != model_bit(img, i)) mism++;
      end else begin
        if (base + i >= bits1.size() || bits1[base + i] != model_bit(img, i)) mism++;
      end
    end
    check("stream_mismatches", mism, 0);
    check("chain", chain[k] & len_mask(sr_len), model_chain(img, sr_len));
    check("done_latency", done_rise_cyc[k], last_en_cyc[k] + 1);
    in_valid[k] = 1'b0;
  endtask

  initial begin
    bytes_q_t img;
    vec_t     tbl[5];
    bit       gaps_ok;
    int       en0, base, ones, seen_ready;

    for (int k = 0; k < 2; k++) begin
      res[k] = 1'b1; start[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = 8'h00;
    end
    do_reset(0);
    do_reset(1);
    #1;
    check("reset_outputs_dut", {in_ready[0], sr_en[0], sr_cfg[0], busy[0], cfg_done[0]}, 0);
    check("reset_outputs_small", {in_ready[1], sr_en[1], sr_cfg[1], busy[1], cfg_done[1]}, 0);

    // Sparse image, in_valid held high: only the first and last streamed bits are 1.
    img = {};
    for (int i = 0; i < 24; i++) img.push_back(i == 0 ? 8'h80 : (i == 23 ? 8'h01 : 8'h00));
    base = bits0.size();
    run_load(0, img, 192, 1'b1, 0, 0, gaps_ok);
    check("chain_first_last", chain[0], (192'd1 << 191) | 192'd1);
    ones = 0;
    for (int i = base; i < bits0.size(); i++) ones += int'(bits0[i]);
    check("ones_in_stream", ones, 2);
    check("first_bit", bits0[base], 1);

    // Same image with 5-cycle valid gaps before every third byte.
    run_load(0, img, 192, 1'b1, 3, 5, gaps_ok);
    check("in_ready_in_gaps", gaps_ok, 1);

    // Small instance: partial last byte, low bits of byte 3 never shifted.
    tbl[0] = '{8'hFF, 8'h00, 8'hF8, 21'h1FE01F, 21};
    tbl[1] = '{8'hFF, 8'h00, 8'hFF, 21'h1FE01F, 21};
    tbl[2] = '{8'hA5, 8'h3C, 8'h07, 21'h14A780, 21};
    tbl[3] = '{8'h80, 8'h00, 8'h08, 21'h100001, 21};
    tbl[4] = '{8'h00, 8'h00, 8'hFF, 21'h00001F, 21};
    for (int t = 0; t < 5; t++) begin
      img = {tbl[t].b0, tbl[t].b1, tbl[t].b2};
      en0 = en_cnt[1];
      run_load(1, img, 21, 1'b1, (t % 2 == 1) ? 2 : 0, 3, gaps_ok);
      check("tbl_chain", chain[1][20:0], tbl[t].exp_chain);
      check("tbl_en", en_cnt[1] - en0, tbl[t].exp_en);
    end

    // Randomised images and gap patterns against the model.
    for (int r = 0; r < 3; r++) begin
      img = {};
      for (int i = 0; i < 24; i++) img.push_back(8'($urandom));
      run_load(0, img, 192, 1'b1, $urandom_range(0, 3), $urandom_range(1, 4), gaps_ok);
      check("rand_gaps", gaps_ok, 1);
    end

    // Abort during the 10th byte's shift phase, then a full reload without another start.
    img = {};
    for (int i = 0; i < 24; i++) img.push_back(8'($urandom));
    pulse_start(0);
    for (int i = 0; i < 10; i++) send_byte(0, img[i], 0, gaps_ok);
    repeat (3) @(negedge clk);
    check("abort_pre_sr_en", sr_en[0], 1);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    #1;
    check("abort_sr_en", sr_en[0], 0);
    check("abort_in_ready", in_ready[0], 1);
    check("abort_status", {busy[0], cfg_done[0]}, 2'b10);
    run_load(0, img, 192, 1'b0, 0, 0, gaps_ok);

    // Reset in the middle of SHIFT, then valid offered without start.
    pulse_start(0);
    send_byte(0, 8'hAA, 0, gaps_ok);
    @(negedge clk);
    res[0] = 1'b1;
    @(negedge clk);
    res[0] = 1'b0;
    #1;
    check("midshift_reset_outputs", {in_ready[0], sr_en[0], sr_cfg[0], busy[0], cfg_done[0]}, 0);
    en0 = en_cnt[0];
    seen_ready = 0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready[0]) seen_ready++;
    end
    check("no_start_in_ready", seen_ready, 0);
    check("no_start_sr_en", en_cnt[0] - en0, 0);

    // start coincident with an offered byte in FETCH: the byte stays on offer.
    in_valid[0] = 1'b0;
    pulse_start(0);
    in_data[0]  = 8'hC3;
    in_valid[0] = 1'b1;
    start[0]    = 1'b1;
    #1;
    check("start_masks_ready", in_ready[0], 0);
    @(negedge clk);
    start[0] = 1'b0;
    #1;
    check("byte_not_consumed", sr_en[0], 0);
    check("ready_after_start", in_ready[0], 1);
    @(negedge clk);
    #1;
    check("byte_accepted_next", {sr_en[0], sr_cfg[0]}, 2'b11);
    do_reset(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
